matmul_sequencer: RTL

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// Sequencer for an external 8x8 weight-stationary systolic array: loads eight
// weight rows, streams A rows with result backpressure, then drains results.
module matmul_sequencer #(
    parameter int unsigned LATENCY  = 10,
    parameter int unsigned MAX_ROWS = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   n_rows,
    output logic         busy,
    output logic         done,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [63:0]  w_data,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [63:0]  a_data,
    output logic         r_valid,
    input  logic         r_ready,
    output logic [159:0] r_data,
    output logic         arr_load,
    output logic         arr_load_w,
    output logic [63:0]  arr_a,
    output logic [63:0]  arr_b,
    output logic [159:0] arr_c,
    input  logic [159:0] arr_out
);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t      state;
    logic [7:0]  rows_q;
    logic [2:0]  w_cnt;
    logic [7:0]  in_cnt;
    logic [7:0]  out_cnt;
    logic [8:0]  adv_cnt;

    logic        advance_ok;
    logic        w_fire;
    logic        a_fire;
    logic        r_fire;
    logic        qualify;

    always_comb begin
        advance_ok = !r_valid || r_ready;
        w_ready    = (state == LOAD_W);
        w_fire     = w_ready && w_valid;
        arr_load_w = w_fire;
        arr_b      = w_fire ? w_data : '0;
        a_ready    = (state == STREAM) && advance_ok;
        a_fire     = a_ready && a_valid;
        arr_a      = a_fire ? a_data : '0;
        arr_load   = a_fire || ((state == DRAIN) && advance_ok);
        arr_c      = '0;
        r_data     = arr_out;
        r_fire     = r_valid && r_ready;
        // Advance k puts row k-(LATENCY-1) on arr_out once the edge completes.
        qualify    = arr_load
                     && (32'(adv_cnt) >= LATENCY - 32'd1)
                     && (32'(adv_cnt) <= LATENCY + 32'(rows_q) - 32'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rows_q  <= '0;
            w_cnt   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            adv_cnt <= '0;
            r_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;

            if (qualify)
                r_valid <= 1'b1;
            else if (r_fire)
                r_valid <= 1'b0;

            if (r_fire)
                out_cnt <= out_cnt + 8'd1;

            if (arr_load && (adv_cnt != '1))
                adv_cnt <= adv_cnt + 9'd1;

            case (state)
                IDLE: begin
                    if (start && (32'(n_rows) <= MAX_ROWS)) begin
                        rows_q  <= n_rows;
                        w_cnt   <= '0;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        adv_cnt <= '0;
                        r_valid <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 3'd1;
                        if (w_cnt == 3'd7) begin
                            if (rows_q != '0) begin
                                state <= STREAM;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                STREAM: begin
                    if (a_fire) begin
                        in_cnt <= in_cnt + 8'd1;
                        if (in_cnt == rows_q - 8'd1)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_fire && (out_cnt == rows_q - 8'd1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
